// File: rtl/xillybus_pkg.sv
// Shared constants and types for the Xillybus user-side stream blocks.
package xillybus_pkg;

    localparam int XB_DW     = 32;
    localparam int XB_DROP_W = 16;

    // Stream mode as seen from the host side of the device file.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2,
        EOF    = 2'd3
    } stream_mode_t;

endpackage

// File: rtl/xillybus_sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read port; the array itself is never reset.
module xillybus_sdp_ram #(
    parameter int AW = 10,
    parameter int W  = 33
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [W-1:0]  wdata_i,
    input  logic          re_i,
    input  logic [AW-1:0] raddr_i,
    output logic [W-1:0]  rdata_o
);

    logic [W-1:0] mem_q [0:(2**AW)-1];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Only the output register takes the reset, so the read word starts at zero.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rdata_o <= '0;
        end else if (re_i) begin
            rdata_o <= mem_q[raddr_i];
        end
    end

endmodule

// File: rtl/xillybus_rd_stream_source.sv
// FPGA->host read-stream producer: circular buffer in front of the core's non-FWFT
// rden/empty/data interface, with end-of-file signalling and drop accounting.
module xillybus_rd_stream_source
    import xillybus_pkg::*;
#(
    parameter int DW        = XB_DW,
    parameter int AW        = 10,
    parameter int AF_THRESH = 992,
    parameter bit EOF_LAST  = 1'b1
) (
    input  logic                 bus_clk,
    input  logic                 bus_rst,
    input  logic                 in_valid,
    input  logic [DW-1:0]        in_data,
    input  logic                 in_last,
    output logic                 almost_full,
    input  logic                 user_r_rd_open,
    input  logic                 user_r_rd_rden,
    output logic [DW-1:0]        user_r_rd_data,
    output logic                 user_r_rd_empty,
    output logic                 user_r_rd_eof,
    output logic [AW:0]          level,
    output logic [XB_DROP_W-1:0] drop_count,
    output logic                 overflow,
    output stream_mode_t         dbg_mode_o,
    output logic                 dbg_rd_last_o
);

    localparam int                   DEPTH    = 2**AW;
    localparam logic [AW:0]          LVL_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0]          LVL_AF   = (AW+1)'(AF_THRESH);
    localparam logic [AW:0]          LVL_ONE  = (AW+1)'(1);
    localparam logic [XB_DROP_W-1:0] DROP_MAX = '1;

    logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [AW:0]          level_q, level_d;
    logic                 empty_q, empty_d;
    logic                 eof_q, eof_d;
    logic                 done_q, done_d;
    logic                 af_q, af_d;
    logic                 ovf_q, ovf_d;
    logic                 open_q;
    logic [XB_DROP_W-1:0] drop_q, drop_d;
    stream_mode_t         mode_q, mode_d;

    logic                 open_rise;
    logic                 full;
    logic                 wr_cand;
    logic                 acc;
    logic                 drop_full;
    logic                 drop_closed;
    logic                 rd;
    logic [DW:0]          ram_rdata;

    // Producer side has no backpressure: a word is either accepted or counted as dropped.
    // Core side is non-FWFT: rden while empty=0 consumes one word, whose data is on
    // user_r_rd_data the following cycle; rden while empty=1 is ignored.
    assign open_rise   = user_r_rd_open & ~open_q;
    assign full        = (level_q == LVL_FULL);
    assign wr_cand     = in_valid & user_r_rd_open & ~done_q;
    assign acc         = wr_cand & ~full;
    assign drop_full   = wr_cand & full;
    assign drop_closed = in_valid & ~user_r_rd_open;
    assign rd          = user_r_rd_rden & ~empty_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        done_d   = done_q;
        eof_d    = eof_q;
        drop_d   = drop_q;
        ovf_d    = ovf_q;

        if (acc) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
            if (in_last && EOF_LAST) begin
                done_d = 1'b1;
            end
        end

        // Once done, nothing else is written, so the final buffered word is the frame-final one.
        if (rd) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            if (done_q && (level_q == LVL_ONE)) begin
                eof_d = 1'b1;
            end
        end

        level_d = level_q + {{AW{1'b0}}, acc} - {{AW{1'b0}}, rd};

        if (!user_r_rd_open) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
            done_d   = 1'b0;
            eof_d    = 1'b0;
        end

        empty_d = (level_d == '0);
        af_d    = (level_d >= LVL_AF);

        if (open_rise) begin
            drop_d = '0;
            ovf_d  = 1'b0;
        end else begin
            if ((drop_full || drop_closed) && (drop_q != DROP_MAX)) begin
                drop_d = drop_q + 1'b1;
            end
            if (drop_full) begin
                ovf_d = 1'b1;
            end
        end

        if (!user_r_rd_open) begin
            mode_d = IDLE;
        end else if (eof_d) begin
            mode_d = EOF;
        end else if (done_d) begin
            mode_d = DRAIN;
        end else begin
            mode_d = STREAM;
        end
    end

    always_ff @(posedge bus_clk) begin
        if (bus_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            empty_q  <= 1'b1;
            eof_q    <= 1'b0;
            done_q   <= 1'b0;
            af_q     <= 1'b0;
            ovf_q    <= 1'b0;
            open_q   <= 1'b0;
            drop_q   <= '0;
            mode_q   <= IDLE;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            empty_q  <= empty_d;
            eof_q    <= eof_d;
            done_q   <= done_d;
            af_q     <= af_d;
            ovf_q    <= ovf_d;
            open_q   <= user_r_rd_open;
            drop_q   <= drop_d;
            mode_q   <= mode_d;
        end
    end

    xillybus_sdp_ram #(
        .AW (AW),
        .W  (DW + 1)
    ) u_ram (
        .clk_i   (bus_clk),
        .rst_i   (bus_rst),
        .we_i    (acc),
        .waddr_i (wr_ptr_q),
        .wdata_i ({in_last, in_data}),
        .re_i    (rd),
        .raddr_i (rd_ptr_q),
        .rdata_o (ram_rdata)
    );

    assign user_r_rd_data  = ram_rdata[DW-1:0];
    assign dbg_rd_last_o   = ram_rdata[DW];
    assign user_r_rd_empty = empty_q;
    assign user_r_rd_eof   = eof_q;
    assign almost_full     = af_q;
    assign level           = level_q;
    assign drop_count      = drop_q;
    assign overflow        = ovf_q;
    assign dbg_mode_o      = mode_q;

endmodule

// File: tb/tb_xillybus_rd_stream_source.sv
// Bench for xillybus_rd_stream_source: directed scenarios plus random traffic, all
// outputs compared every cycle against a queue-based model of the stream.
module tb_xillybus_rd_stream_source;
    import xillybus_pkg::*;

    localparam int DW    = 32;
    localparam int AW    = 4;
    localparam int DEPTH = 16;
    localparam int AF    = 12;

    logic               bus_clk = 1'b0;
    logic               bus_rst;
    logic               in_valid;
    logic [DW-1:0]      in_data;
    logic               in_last;
    logic               almost_full;
    logic               user_r_rd_open;
    logic               user_r_rd_rden;
    logic [DW-1:0]      user_r_rd_data;
    logic               user_r_rd_empty;
    logic               user_r_rd_eof;
    logic [AW:0]        level;
    logic [15:0]        drop_count;
    logic               overflow;
    stream_mode_t       dbg_mode_o;
    logic               dbg_rd_last_o;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    // Reference model: buffered words as {last, data}, plus file-level flags.
    logic [DW:0]   exp_q[$];
    logic [DW-1:0] m_data = '0;
    logic          m_done = 1'b0;
    logic          m_eof = 1'b0;
    logic          m_ovf = 1'b0;
    logic          m_prev_open = 1'b0;
    int            m_drop = 0;
    stream_mode_t  m_mode = IDLE;

    logic [DW-1:0] ovf_words [20];

    xillybus_rd_stream_source #(
        .DW        (DW),
        .AW        (AW),
        .AF_THRESH (AF),
        .EOF_LAST  (1'b1)
    ) dut (
        .bus_clk         (bus_clk),
        .bus_rst         (bus_rst),
        .in_valid        (in_valid),
        .in_data         (in_data),
        .in_last         (in_last),
        .almost_full     (almost_full),
        .user_r_rd_open  (user_r_rd_open),
        .user_r_rd_rden  (user_r_rd_rden),
        .user_r_rd_data  (user_r_rd_data),
        .user_r_rd_empty (user_r_rd_empty),
        .user_r_rd_eof   (user_r_rd_eof),
        .level           (level),
        .drop_count      (drop_count),
        .overflow        (overflow),
        .dbg_mode_o      (dbg_mode_o),
        .dbg_rd_last_o   (dbg_rd_last_o)
    );

    always #5 bus_clk = ~bus_clk;

    always @(posedge bus_clk) begin : model
        int lvl;
        logic [DW:0] w;
        if (bus_rst) begin
            exp_q.delete();
            m_data = '0;
            m_done = 1'b0;
            m_eof = 1'b0;
            m_ovf = 1'b0;
            m_drop = 0;
            m_prev_open = 1'b0;
        end else begin
            lvl = exp_q.size();
            if (in_valid && user_r_rd_open && !m_done && lvl == DEPTH) begin
                if (m_drop < 65535) m_drop++;
                m_ovf = 1'b1;
            end
            if (in_valid && !user_r_rd_open && m_drop < 65535) m_drop++;
            if (user_r_rd_open && !m_prev_open) begin
                m_drop = 0;
                m_ovf = 1'b0;
            end
            if (user_r_rd_rden && lvl > 0) begin
                w = exp_q.pop_front();
                m_data = w[DW-1:0];
                if (w[DW]) m_eof = 1'b1;
            end
            if (in_valid && user_r_rd_open && !m_done && lvl < DEPTH) begin
                exp_q.push_back({in_last, in_data});
                if (in_last) m_done = 1'b1;
            end
            if (!user_r_rd_open) begin
                exp_q.delete();
                m_done = 1'b0;
                m_eof = 1'b0;
            end
            m_prev_open = user_r_rd_open;
        end
        if (!m_prev_open) m_mode = IDLE;
        else if (m_eof) m_mode = EOF;
        else if (m_done) m_mode = DRAIN;
        else m_mode = STREAM;
    end

    always @(negedge bus_clk) begin
        if (chk_en) begin
            n_cmp += 9;
            if (level !== (AW+1)'(exp_q.size())) begin
                n_bad++; $display("FAIL sb_level t=%0t got %0d want %0d", $time, level, exp_q.size());
            end
            if (user_r_rd_empty !== (exp_q.size() == 0)) begin
                n_bad++; $display("FAIL sb_empty t=%0t got %0b want %0b", $time, user_r_rd_empty, exp_q.size() == 0);
            end
            if (user_r_rd_eof !== m_eof) begin
                n_bad++; $display("FAIL sb_eof t=%0t got %0b want %0b", $time, user_r_rd_eof, m_eof);
            end
            if (user_r_rd_data !== m_data) begin
                n_bad++; $display("FAIL sb_data t=%0t got %h want %h", $time, user_r_rd_data, m_data);
            end
            if (drop_count !== 16'(m_drop)) begin
                n_bad++; $display("FAIL sb_drop t=%0t got %0d want %0d", $time, drop_count, m_drop);
            end
            if (overflow !== m_ovf) begin
                n_bad++; $display("FAIL sb_overflow t=%0t got %0b want %0b", $time, overflow, m_ovf);
            end
            if (almost_full !== (exp_q.size() >= AF)) begin
                n_bad++; $display("FAIL sb_almost_full t=%0t got %0b want %0b", $time, almost_full, exp_q.size() >= AF);
            end
            if (dbg_mode_o !== m_mode) begin
                n_bad++; $display("FAIL sb_mode t=%0t got %0d want %0d", $time, dbg_mode_o, m_mode);
            end
            if (user_r_rd_eof && !user_r_rd_empty) begin
                n_bad++; $display("FAIL sb_eof_implies_empty t=%0t eof=1 empty=0", $time);
            end
        end
    end

    task automatic cyc();
        @(posedge bus_clk);
        #1;
    endtask

    task automatic write_word(input logic [DW-1:0] d, input logic last);
        in_valid = 1'b1;
        in_data = d;
        in_last = last;
        cyc();
        in_valid = 1'b0;
        in_last = 1'b0;
    endtask

    task automatic read_word();
        user_r_rd_rden = 1'b1;
        cyc();
        user_r_rd_rden = 1'b0;
    endtask

    task automatic test_reset();
        bus_rst = 1'b1;
        in_valid = 1'b0;
        in_data = '0;
        in_last = 1'b0;
        user_r_rd_open = 1'b0;
        user_r_rd_rden = 1'b0;
        cyc();
        cyc();
        n_cmp += 8;
        if (level !== '0) begin n_bad++; $display("FAIL rst_level got %0d want 0", level); end
        if (user_r_rd_empty !== 1'b1) begin n_bad++; $display("FAIL rst_empty got %0b want 1", user_r_rd_empty); end
        if (user_r_rd_eof !== 1'b0) begin n_bad++; $display("FAIL rst_eof got %0b want 0", user_r_rd_eof); end
        if (user_r_rd_data !== '0) begin n_bad++; $display("FAIL rst_data got %h want 0", user_r_rd_data); end
        if (drop_count !== '0) begin n_bad++; $display("FAIL rst_drop got %0d want 0", drop_count); end
        if (overflow !== 1'b0) begin n_bad++; $display("FAIL rst_overflow got %0b want 0", overflow); end
        if (almost_full !== 1'b0) begin n_bad++; $display("FAIL rst_almost_full got %0b want 0", almost_full); end
        if (dbg_mode_o !== IDLE) begin n_bad++; $display("FAIL rst_mode got %0d want IDLE", dbg_mode_o); end
        bus_rst = 1'b0;
        chk_en = 1'b1;
    endtask

    task automatic test_basic_frame();
        user_r_rd_open = 1'b1;
        cyc();
        for (int i = 0; i < 5; i++) write_word(32'h100 + 32'(i), i == 4);
        n_cmp += 2;
        if (level !== 5'd5) begin n_bad++; $display("FAIL basic_level got %0d want 5", level); end
        if (dbg_mode_o !== DRAIN) begin n_bad++; $display("FAIL basic_mode_drain got %0d want DRAIN", dbg_mode_o); end
        for (int i = 0; i < 5; i++) begin
            read_word();
            n_cmp++;
            if (user_r_rd_data !== 32'h100 + 32'(i)) begin
                n_bad++; $display("FAIL basic_data[%0d] got %h want %h", i, user_r_rd_data, 32'h100 + 32'(i));
            end
        end
        n_cmp += 3;
        if (user_r_rd_empty !== 1'b1) begin n_bad++; $display("FAIL basic_empty got %0b want 1", user_r_rd_empty); end
        if (user_r_rd_eof !== 1'b1) begin n_bad++; $display("FAIL basic_eof got %0b want 1", user_r_rd_eof); end
        if (dbg_mode_o !== EOF) begin n_bad++; $display("FAIL basic_mode_eof got %0d want EOF", dbg_mode_o); end
        read_word();
        n_cmp += 2;
        if (user_r_rd_data !== 32'h104) begin n_bad++; $display("FAIL basic_extra_rden_data got %h want 104", user_r_rd_data); end
        if (level !== '0) begin n_bad++; $display("FAIL basic_extra_rden_level got %0d want 0", level); end
        user_r_rd_open = 1'b0;
        cyc();
        n_cmp++;
        if (user_r_rd_eof !== 1'b0) begin n_bad++; $display("FAIL basic_close_eof got %0b want 0", user_r_rd_eof); end
    endtask

    task automatic test_overflow();
        user_r_rd_open = 1'b1;
        cyc();
        for (int i = 0; i < 20; i++) begin
            ovf_words[i] = $urandom;
            write_word(ovf_words[i], 1'b0);
        end
        n_cmp += 4;
        if (level !== 5'd16) begin n_bad++; $display("FAIL ovf_level got %0d want 16", level); end
        if (drop_count !== 16'd4) begin n_bad++; $display("FAIL ovf_drop got %0d want 4", drop_count); end
        if (overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_sticky got %0b want 1", overflow); end
        if (almost_full !== 1'b1) begin n_bad++; $display("FAIL ovf_almost_full got %0b want 1", almost_full); end
    endtask

    task automatic test_full_read_write();
        in_valid = 1'b1;
        in_data = $urandom;
        user_r_rd_rden = 1'b1;
        cyc();
        in_valid = 1'b0;
        user_r_rd_rden = 1'b0;
        n_cmp += 3;
        if (drop_count !== 16'd5) begin n_bad++; $display("FAIL fullrw_drop got %0d want 5", drop_count); end
        if (level !== 5'd15) begin n_bad++; $display("FAIL fullrw_level got %0d want 15", level); end
        if (user_r_rd_data !== ovf_words[0]) begin n_bad++; $display("FAIL fullrw_data got %h want %h", user_r_rd_data, ovf_words[0]); end
        for (int i = 1; i < 16; i++) begin
            read_word();
            n_cmp++;
            if (user_r_rd_data !== ovf_words[i]) begin
                n_bad++; $display("FAIL fullrw_drain[%0d] got %h want %h", i, user_r_rd_data, ovf_words[i]);
            end
        end
        n_cmp += 2;
        if (user_r_rd_empty !== 1'b1) begin n_bad++; $display("FAIL fullrw_empty got %0b want 1", user_r_rd_empty); end
        if (overflow !== 1'b1) begin n_bad++; $display("FAIL fullrw_ovf_kept got %0b want 1", overflow); end
    endtask

    task automatic test_close_reopen();
        for (int i = 0; i < 3; i++) write_word($urandom, 1'b0);
        user_r_rd_open = 1'b0;
        cyc();
        user_r_rd_open = 1'b1;
        cyc();
        n_cmp += 5;
        if (user_r_rd_empty !== 1'b1) begin n_bad++; $display("FAIL reopen_empty got %0b want 1", user_r_rd_empty); end
        if (level !== '0) begin n_bad++; $display("FAIL reopen_level got %0d want 0", level); end
        if (user_r_rd_eof !== 1'b0) begin n_bad++; $display("FAIL reopen_eof got %0b want 0", user_r_rd_eof); end
        if (drop_count !== '0) begin n_bad++; $display("FAIL reopen_drop got %0d want 0", drop_count); end
        if (overflow !== 1'b0) begin n_bad++; $display("FAIL reopen_ovf got %0b want 0", overflow); end
        write_word(32'hABCD, 1'b0);
        n_cmp++;
        if (user_r_rd_empty !== 1'b0) begin n_bad++; $display("FAIL reopen_wr_latency got empty=%0b want 0", user_r_rd_empty); end
        read_word();
        n_cmp++;
        if (user_r_rd_data !== 32'hABCD) begin n_bad++; $display("FAIL reopen_data got %h want 0000abcd", user_r_rd_data); end
    endtask

    task automatic test_closed_drops();
        user_r_rd_open = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 7; i++) begin
            in_data = $urandom;
            cyc();
        end
        in_valid = 1'b0;
        n_cmp += 3;
        if (drop_count !== 16'd7) begin n_bad++; $display("FAIL closed_drop got %0d want 7", drop_count); end
        if (overflow !== 1'b0) begin n_bad++; $display("FAIL closed_ovf got %0b want 0", overflow); end
        if (user_r_rd_empty !== 1'b1) begin n_bad++; $display("FAIL closed_empty got %0b want 1", user_r_rd_empty); end
    endtask

    task automatic test_random_traffic();
        user_r_rd_open = 1'b1;
        for (int c = 0; c < 800; c++) begin
            user_r_rd_open = ($urandom_range(0, 149) != 0);
            in_valid = ($urandom_range(0, 3) != 0);
            in_data = $urandom;
            in_last = ($urandom_range(0, 40) == 0);
            user_r_rd_rden = ($urandom_range(0, 2) != 0);
            cyc();
        end
        in_valid = 1'b0;
        in_last = 1'b0;
        user_r_rd_rden = 1'b0;
        user_r_rd_open = 1'b1;
        cyc();
        n_cmp++;
        if (level !== (AW+1)'(exp_q.size())) begin
            n_bad++; $display("FAIL random_final_level got %0d want %0d", level, exp_q.size());
        end
    endtask

    task automatic test_mid_reset();
        user_r_rd_open = 1'b0;
        cyc();
        user_r_rd_open = 1'b1;
        cyc();
        for (int i = 0; i < 10; i++) write_word(32'h55AA_0000 | 32'(i), i == 9);
        read_word();
        n_cmp += 3;
        if (level !== 5'd9) begin n_bad++; $display("FAIL midrst_pre_level got %0d want 9", level); end
        if (user_r_rd_data !== 32'h55AA_0000) begin n_bad++; $display("FAIL midrst_pre_data got %h want 55aa0000", user_r_rd_data); end
        if (dbg_mode_o !== DRAIN) begin n_bad++; $display("FAIL midrst_pre_mode got %0d want DRAIN", dbg_mode_o); end
        bus_rst = 1'b1;
        cyc();
        bus_rst = 1'b0;
        n_cmp += 5;
        if (level !== '0) begin n_bad++; $display("FAIL midrst_level got %0d want 0", level); end
        if (user_r_rd_empty !== 1'b1) begin n_bad++; $display("FAIL midrst_empty got %0b want 1", user_r_rd_empty); end
        if (user_r_rd_eof !== 1'b0) begin n_bad++; $display("FAIL midrst_eof got %0b want 0", user_r_rd_eof); end
        if (user_r_rd_data !== '0) begin n_bad++; $display("FAIL midrst_data got %h want 0", user_r_rd_data); end
        if (dbg_mode_o !== IDLE) begin n_bad++; $display("FAIL midrst_mode got %0d want IDLE", dbg_mode_o); end
        cyc();
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_overflow();
        test_full_read_write();
        test_close_reopen();
        test_closed_drops();
        test_random_traffic();
        test_mid_reset();
        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
